// File: rtl/pio_sensor_in.sv
// pio_sensor_in: Avalon-MM input PIO for alarm sensor lines.
// Each pin is synchronised, debounced and edge-detected. Selected edges latch into a
// write-1-to-clear capture register, which raises a maskable level interrupt.
module pio_sensor_in #(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [CW-1:0]    r_cnt  [WIDTH];
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_debD;
    logic [WIDTH-1:0] r_irqMask;
    logic [WIDTH-1:0] r_edgeCap;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edges;
    logic [WIDTH-1:0] w_clr;
    logic             w_wrEn;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_wrEn = chipselect && !write_n;

    // Shift the asynchronous pins through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Per-bit debounce: the value flips only after a run of consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_deb <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_sync[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= w_sync[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed copy of the debounced value used for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_debD <= '0;
        end else begin
            r_debD <= r_deb;
        end
    end

    // Pick the edge polarity that is allowed to set capture bits.
    always_comb begin
        w_rise  = r_deb & ~r_debD;
        w_fall  = ~r_deb & r_debD;
        w_edges = '0;
        if (EDGE_TYPE == 0) begin
            w_edges = w_rise;
        end else if (EDGE_TYPE == 1) begin
            w_edges = w_fall;
        end else begin
            w_edges = w_rise | w_fall;
        end
        w_clr = '0;
        if (w_wrEn && (address == 2'd3)) begin
            w_clr = writedata[WIDTH-1:0];
        end
    end

    // Interrupt mask register, written through the bus.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irqMask <= '0;
        end else if (w_wrEn && (address == 2'd2)) begin
            r_irqMask <= writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture; a new edge beats a simultaneous clear of the same bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_edgeCap <= '0;
        end else begin
            r_edgeCap <= (r_edgeCap & ~w_clr) | w_edges;
        end
    end

    // Read mux depends only on address so the bus sees zero wait states.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = r_deb;
            2'd2:    readdata[WIDTH-1:0] = r_irqMask;
            2'd3:    readdata[WIDTH-1:0] = r_edgeCap;
            default: readdata = '0;
        endcase
    end

    assign irq = |(r_edgeCap & r_irqMask);

endmodule
